// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared memory port
// seen by imem_dmem_arbiter. The slave modport is the arbiter's view.
interface imem_dmem_arbiter_if #(
    parameter int NB_ADDR = 32,
    parameter int NB_WORD = 32
);
    // Handshake: a requester raises req with stable addr/data and holds them
    // until it sees gnt high in the same cycle; a granted read returns exactly
    // once on that requester's rvalid, with rdata meaningful only while rvalid=1.
    logic               i_f_req;
    logic [NB_ADDR-1:0] i_f_addr;
    logic               o_f_gnt;
    logic               o_f_rvalid;
    logic [NB_WORD-1:0] o_f_rdata;

    logic               i_d_req;
    logic               i_d_we;
    logic [NB_ADDR-1:0] i_d_addr;
    logic [NB_WORD-1:0] i_d_wdata;
    logic [3:0]         i_d_be;
    logic               o_d_gnt;
    logic               o_d_rvalid;
    logic [NB_WORD-1:0] o_d_rdata;

    logic               o_mem_en;
    logic               o_mem_we;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NB_WORD-1:0] o_mem_wdata;
    logic [3:0]         o_mem_be;
    logic [NB_WORD-1:0] i_mem_rdata;

    // 1 while a read is outstanding (RD_WAIT)
    logic               o_dbg_busy;

    modport slave (
        input  i_f_req, i_f_addr,
        output o_f_gnt, o_f_rvalid, o_f_rdata,
        input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  i_mem_rdata,
        output o_dbg_busy
    );

    modport master (
        output i_f_req, i_f_addr,
        input  o_f_gnt, o_f_rvalid, o_f_rdata,
        output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output i_mem_rdata,
        input  o_dbg_busy
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the fetch (F) and load/store (D) ports onto one single-port
// memory with fixed read latency; D has priority, F is protected from starvation.
module imem_dmem_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    imem_dmem_arbiter_if.slave  bus
);
    localparam int NB_LAT = $clog2(MEM_LAT + 1);
    localparam int NB_STV = $clog2(STARVE_LIMIT + 1);
    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic [NB_LAT-1:0]   r_lat_cnt;
    logic [NB_STV-1:0]   r_starve_cnt;
    logic                r_owner;

    logic w_ret;
    logic w_rvalid;
    logic w_free;
    logic w_f_force;
    logic w_f_win;
    logic w_d_win;
    logic w_rd_grant;

    // The return cycle of a read doubles as a free slot for the next grant.
    assign w_ret      = (r_state == RD_WAIT) && (r_lat_cnt == NB_LAT'(1));
    assign w_rvalid   = w_ret && !i_reset;
    assign w_free     = !i_reset && ((r_state == IDLE) || w_ret);
    assign w_f_force  = (r_starve_cnt == NB_STV'(STARVE_LIMIT)) && bus.i_f_req;
    assign w_f_win    = w_free && (w_f_force || (!bus.i_d_req && bus.i_f_req));
    assign w_d_win    = w_free && !w_f_force && bus.i_d_req;
    assign w_rd_grant = w_f_win || (w_d_win && !bus.i_d_we);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_owner      <= OWN_F;
        end else begin
            if (w_rd_grant) begin
                r_owner   <= w_d_win ? OWN_D : OWN_F;
                r_lat_cnt <= NB_LAT'(MEM_LAT);
                r_state   <= RD_WAIT;
            end else if (r_state == RD_WAIT) begin
                r_lat_cnt <= r_lat_cnt - NB_LAT'(1);
                if (w_ret) r_state <= IDLE;
            end

            if (!bus.i_f_req || w_f_win)
                r_starve_cnt <= '0;
            else if (r_starve_cnt != NB_STV'(STARVE_LIMIT))
                r_starve_cnt <= r_starve_cnt + NB_STV'(1);
        end
    end

    always_comb begin
        bus.o_f_gnt     = w_f_win;
        bus.o_d_gnt     = w_d_win;
        bus.o_mem_en    = w_f_win || w_d_win;
        bus.o_mem_we    = w_d_win && bus.i_d_we;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_be    = '0;
        if (w_d_win) begin
            bus.o_mem_addr  = bus.i_d_addr;
            bus.o_mem_wdata = bus.i_d_wdata;
            bus.o_mem_be    = bus.i_d_be;
        end else if (w_f_win) begin
            bus.o_mem_addr  = bus.i_f_addr;
            bus.o_mem_be    = 4'hF;
        end

        bus.o_f_rvalid = w_rvalid && (r_owner == OWN_F);
        bus.o_d_rvalid = w_rvalid && (r_owner == OWN_D);
        bus.o_f_rdata  = bus.o_f_rvalid ? bus.i_mem_rdata : '0;
        bus.o_d_rdata  = bus.o_d_rvalid ? bus.i_mem_rdata : '0;
        bus.o_dbg_busy = (r_state == RD_WAIT);
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: one instance at MEM_LAT=1 and one at
// MEM_LAT=3 share the stimulus; sel picks which one is checked.
module tb_imem_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        f_req, d_req, d_we;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_f_q[$];
    logic [31:0] exp_d_q[$];

    always #5 clk = ~clk;

    imem_dmem_arbiter_if #(.NB_ADDR(32), .NB_WORD(32)) if1 ();
    imem_dmem_arbiter_if #(.NB_ADDR(32), .NB_WORD(32)) if3 ();

    imem_dmem_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(4)) u_dut1 (
        .i_clock(clk), .i_reset(rst), .bus(if1.slave));
    imem_dmem_arbiter #(.MEM_LAT(3), .STARVE_LIMIT(4)) u_dut3 (
        .i_clock(clk), .i_reset(rst), .bus(if3.slave));

    assign if1.i_f_req = f_req;   assign if3.i_f_req = f_req;
    assign if1.i_f_addr = f_addr; assign if3.i_f_addr = f_addr;
    assign if1.i_d_req = d_req;   assign if3.i_d_req = d_req;
    assign if1.i_d_we = d_we;     assign if3.i_d_we = d_we;
    assign if1.i_d_addr = d_addr; assign if3.i_d_addr = d_addr;
    assign if1.i_d_wdata = d_wdata; assign if3.i_d_wdata = d_wdata;
    assign if1.i_d_be = d_be;     assign if3.i_d_be = d_be;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    // Memory models: address pipelines of depth 1 and 3
    logic [31:0] m1_a;
    logic [31:0] m3_a0, m3_a1, m3_a2;
    always @(posedge clk) begin
        m1_a  <= if1.o_mem_addr;
        m3_a0 <= if3.o_mem_addr;
        m3_a1 <= m3_a0;
        m3_a2 <= m3_a1;
    end
    assign if1.i_mem_rdata = mem_word(m1_a);
    assign if3.i_mem_rdata = mem_word(m3_a2);

    logic        o_f_gnt, o_d_gnt, o_f_rv, o_d_rv, o_en, o_we, o_busy;
    logic [31:0] o_f_rd, o_d_rd, o_addr, o_wdata;
    logic [3:0]  o_be;
    assign o_f_gnt = sel ? if3.o_f_gnt    : if1.o_f_gnt;
    assign o_d_gnt = sel ? if3.o_d_gnt    : if1.o_d_gnt;
    assign o_f_rv  = sel ? if3.o_f_rvalid : if1.o_f_rvalid;
    assign o_d_rv  = sel ? if3.o_d_rvalid : if1.o_d_rvalid;
    assign o_f_rd  = sel ? if3.o_f_rdata  : if1.o_f_rdata;
    assign o_d_rd  = sel ? if3.o_d_rdata  : if1.o_d_rdata;
    assign o_en    = sel ? if3.o_mem_en   : if1.o_mem_en;
    assign o_we    = sel ? if3.o_mem_we   : if1.o_mem_we;
    assign o_addr  = sel ? if3.o_mem_addr : if1.o_mem_addr;
    assign o_wdata = sel ? if3.o_mem_wdata : if1.o_mem_wdata;
    assign o_be    = sel ? if3.o_mem_be   : if1.o_mem_be;
    assign o_busy  = sel ? if3.o_dbg_busy : if1.o_dbg_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle at the falling edge, then return just after the next rising edge.
    task automatic cyc(input string tag, input logic ef, input logic ed,
                       input logic erf, input logic erd);
        logic [31:0] e_addr, e_wdata, e_rd;
        logic [3:0]  e_be;
        @(negedge clk);
        e_addr  = ed ? d_addr  : (ef ? f_addr : 32'h0);
        e_wdata = ed ? d_wdata : 32'h0;
        e_be    = ed ? d_be    : (ef ? 4'hF : 4'h0);
        chk({tag, ".f_gnt"},  o_f_gnt, ef);
        chk({tag, ".d_gnt"},  o_d_gnt, ed);
        chk({tag, ".mem_en"}, o_en, ef | ed);
        chk({tag, ".mem_we"}, o_we, ed & d_we);
        chk({tag, ".mem_addr"},  o_addr,  e_addr);
        chk({tag, ".mem_wdata"}, o_wdata, e_wdata);
        chk({tag, ".mem_be"},    o_be,    e_be);
        chk({tag, ".f_rvalid"}, o_f_rv, erf);
        chk({tag, ".d_rvalid"}, o_d_rv, erd);
        e_rd = 32'h0;
        if (erf && exp_f_q.size() > 0) e_rd = exp_f_q.pop_front();
        chk({tag, ".f_rdata"}, o_f_rd, e_rd);
        e_rd = 32'h0;
        if (erd && exp_d_q.size() > 0) e_rd = exp_d_q.pop_front();
        chk({tag, ".d_rdata"}, o_d_rd, e_rd);
        if (ef) exp_f_q.push_back(mem_word(f_addr));
        if (ed && !d_we) exp_d_q.push_back(mem_word(d_addr));
        @(posedge clk);
        #1;
    endtask

    initial begin
        sel = 1'b0; rst = 1'b1;
        f_req = 1'b1; f_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        d_wdata = 32'h0; d_be = 4'hF;
        @(posedge clk); #1;

        // reset with both requesting, then D wins and starvation forces F at cycle 4
        cyc("rst0", 0, 0, 0, 0);
        cyc("rst1", 0, 0, 0, 0);
        rst = 1'b0;
        cyc("arb_c0", 0, 1, 0, 0);
        cyc("arb_c1", 0, 1, 0, 1);
        cyc("arb_c2", 0, 1, 0, 1);
        cyc("arb_c3", 0, 1, 0, 1);
        cyc("arb_c4", 1, 0, 0, 1);
        cyc("arb_c5", 0, 1, 1, 0);
        f_req = 1'b0; d_req = 1'b0;
        cyc("arb_c6", 0, 0, 0, 1);

        // back-to-back fetches
        f_req = 1'b1; f_addr = 32'h0;
        cyc("f_a0", 1, 0, 0, 0);
        f_addr = 32'h4;
        cyc("f_a4", 1, 0, 1, 0);
        f_addr = 32'h8;
        cyc("f_a8", 1, 0, 1, 0);
        f_req = 1'b0;
        cyc("f_end", 0, 0, 1, 0);

        // write beats pending fetch, then fetch next cycle
        f_req = 1'b1; f_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100;
        d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        cyc("wr", 0, 1, 0, 0);
        d_req = 1'b0; d_we = 1'b0;
        cyc("wr_f", 1, 0, 0, 0);
        f_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104;
        d_wdata = $urandom_range(32'hFFFF, 0); d_be = 4'($urandom_range(15, 0));
        cyc("wr_b2b0", 0, 1, 1, 0);
        d_addr = 32'h108; d_wdata = 32'h12345678; d_be = 4'b1100;
        cyc("wr_b2b1", 0, 1, 0, 0);
        d_req = 1'b0; d_we = 1'b0; d_be = 4'hF;
        cyc("wr_idle", 0, 0, 0, 0);

        // MEM_LAT=3 instance
        sel = 1'b1; rst = 1'b1;
        exp_f_q.delete(); exp_d_q.delete();
        cyc("l3_rst0", 0, 0, 0, 0);
        cyc("l3_rst1", 0, 0, 0, 0);
        rst = 1'b0;
        f_req = 1'b1; f_addr = 32'h20;
        cyc("l3_t0", 1, 0, 0, 0);
        f_req = 1'b0; d_req = 1'b1; d_addr = 32'h300;
        cyc("l3_t1", 0, 0, 0, 0);
        cyc("l3_t2", 0, 0, 0, 0);
        cyc("l3_t3", 0, 1, 1, 0);
        d_req = 1'b0;
        cyc("l3_t4", 0, 0, 0, 0);
        cyc("l3_t5", 0, 0, 0, 0);
        cyc("l3_t6", 0, 0, 0, 1);
        chk("l3_idle", o_busy, 1'b0);

        // reset during an outstanding read drops it
        f_req = 1'b1; f_addr = 32'h30;
        cyc("rr_t0", 1, 0, 0, 0);
        chk("rr_busy", o_busy, 1'b1);
        f_req = 1'b0; rst = 1'b1;
        cyc("rr_t1", 0, 0, 0, 0);
        rst = 1'b0;
        exp_f_q.delete();
        chk("rr_idle", o_busy, 1'b0);
        cyc("rr_t2", 0, 0, 0, 0);
        cyc("rr_t3", 0, 0, 0, 0);
        cyc("rr_t4", 0, 0, 0, 0);
        f_req = 1'b1; f_addr = 32'h34;
        cyc("rr_n0", 1, 0, 0, 0);
        f_req = 1'b0;
        cyc("rr_n1", 0, 0, 0, 0);
        cyc("rr_n2", 0, 0, 0, 0);
        cyc("rr_n3", 0, 0, 1, 0);

        chk("f_q_left", 64'(exp_f_q.size()), 64'd0);
        chk("d_q_left", 64'(exp_d_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
